nios_key_input_pio: RTL and testbench

//  Avalon-MM slave input port: the read-side counterpart of the LED output PIO.

---
 rtl/nios_key_input_pio_if.sv | 18 +
 rtl/nios_key_input_pio.sv | 94 +++++++++
 tb/tb_nios_key_input_pio.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/nios_key_input_pio_if.sv
// Avalon-MM slave bus bundle for the key input PIO.
interface nios_key_input_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_key_input_pio.sv
// Key/switch input PIO: two-flop synchroniser, per-line debounce, edge capture
// with W1C clear, maskable level interrupt and an Avalon-MM register file.
module nios_key_input_pio #(
  parameter int unsigned     WIDTH           = 4,
  parameter int unsigned     DEBOUNCE_CYCLES = 50000,
  parameter bit              EDGE_FALLING    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE    = WIDTH'(4'hF)
) (
  input  logic                  clk,
  input  logic                  reset,
  nios_key_input_pio_if.slave   bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [31:0]      rd_d;
  logic             wr_en;

  assign wr_en = bus.chipselect && !bus.write_n;

  // Debounce: a line must disagree with the accepted level for DEBOUNCE_CYCLES in a row.
  always_comb begin
    deb_d    = deb_q;
    edge_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i]    = sync_q[i];
          edge_set[i] = (sync_q[i] != EDGE_FALLING);
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Register writes; a fresh edge outranks a simultaneous W1C on the same bit.
  always_comb begin
    mask_d = mask_q;
    w1c    = '0;
    if (wr_en && (bus.address == ADDR_IRQMASK)) mask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && (bus.address == ADDR_EDGECAP)) w1c    = bus.writedata[WIDTH-1:0];
    ecap_d = (ecap_q & ~w1c) | edge_set;
  end

  always_comb begin
    rd_d = '0;
    case (bus.address)
      ADDR_DATA:    rd_d = 32'(deb_q);
      ADDR_IRQMASK: rd_d = 32'(mask_q);
      ADDR_EDGECAP: rd_d = 32'(ecap_q);
      default:      rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q       <= RESET_VALUE;
      sync_q       <= RESET_VALUE;
      deb_q        <= RESET_VALUE;
      mask_q       <= '0;
      ecap_q       <= '0;
      bus.readdata <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      meta_q       <= in_port;
      sync_q       <= meta_q;
      deb_q        <= deb_d;
      mask_q       <= mask_d;
      ecap_q       <= ecap_d;
      bus.readdata <= rd_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign irq = |(ecap_q & mask_q);

endmodule

// File: tb/tb_nios_key_input_pio.sv
// Bench for nios_key_input_pio: directed vector table, corner sequences and
// randomized traffic checked against a cycle reference model.
module tb_nios_key_input_pio;

  localparam int unsigned W = 4;
  localparam int unsigned D = 4;
  localparam logic [3:0]  RV = 4'hF;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_port;
  logic       irq;

  nios_key_input_pio_if bus_if ();

  nios_key_input_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_FALLING(1'b1), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: input history, accepted levels, disagreement run lengths.
  logic [3:0]  hist [$];
  logic [3:0]  m_deb, m_mask, m_ecap;
  logic [31:0] m_rd;
  int          m_run [4];

  task automatic model_step(input logic rst, input logic wr, input logic [1:0] a,
                            input logic [31:0] wd, input logic [3:0] ip);
    logic [3:0] s, nd, setb;
    if (rst) begin
      hist.delete();
      hist.push_back(RV);
      hist.push_back(RV);
      m_deb = RV; m_mask = '0; m_ecap = '0; m_rd = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      return;
    end
    // synchronised view = in_port as sampled two edges ago
    s = hist[hist.size()-2];
    case (a)
      2'd0: m_rd = {28'd0, m_deb};
      2'd2: m_rd = {28'd0, m_mask};
      2'd3: m_rd = {28'd0, m_ecap};
      default: m_rd = '0;
    endcase
    nd = m_deb; setb = '0;
    for (int i = 0; i < 4; i++) begin
      if (s[i] == m_deb[i]) m_run[i] = 0;
      else begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin
          nd[i] = s[i];
          m_run[i] = 0;
          if (s[i] == 1'b0) setb[i] = 1'b1;
        end
      end
    end
    if (wr && a == 2'd2) m_mask = wd[3:0];
    if (wr && a == 2'd3) m_ecap = m_ecap & ~wd[3:0];
    m_ecap = m_ecap | setb;
    m_deb  = nd;
    hist.push_back(ip);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, advance model, compare at following negedge.
  task automatic cyc(input logic rst, input logic wr, input logic [1:0] a,
                     input logic [31:0] wd, input logic [3:0] ip);
    reset              = rst;
    bus_if.chipselect  = wr | ($urandom_range(0, 1) == 1);
    bus_if.write_n     = ~wr;
    bus_if.address     = a;
    bus_if.writedata   = wd;
    in_port            = ip;
    model_step(rst, wr, a, wd, ip);
    @(negedge clk);
    check32("model_readdata", bus_if.readdata, m_rd);
    check32("model_irq", {31'd0, irq}, {31'd0, |(m_ecap & m_mask)});
  endtask

  typedef struct {
    logic        rst;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [3:0]  inp;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t v(input logic r, input logic w, input logic [1:0] a,
                             input logic [31:0] d, input logic [3:0] ip,
                             input logic [31:0] er, input logic ei);
    vec_t t;
    t.rst = r; t.wr = w; t.addr = a; t.wd = d; t.inp = ip; t.exp_rd = er; t.exp_irq = ei;
    return t;
  endfunction

  initial begin
    reset = 1'b1; in_port = RV;
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    bus_if.address = '0; bus_if.writedata = '0;

    // reset and idle reads
    tbl.push_back(v(1, 0, 0, 0, 4'hF, 32'h0, 0));
    tbl.push_back(v(0, 0, 0, 0, 4'hF, 32'hF, 0));
    tbl.push_back(v(0, 0, 2, 0, 4'hF, 32'h0, 0));
    tbl.push_back(v(0, 0, 3, 0, 4'hF, 32'h0, 0));
    // key 0 pressed and held
    for (int i = 0; i < 6; i++) tbl.push_back(v(0, 0, 0, 0, 4'hE, 32'hF, 0));
    tbl.push_back(v(0, 0, 0, 0, 4'hE, 32'hE, 0));
    tbl.push_back(v(0, 0, 3, 0, 4'hE, 32'h1, 0));
    // key 1 glitch of 3 clocks
    for (int i = 0; i < 3; i++) tbl.push_back(v(0, 0, 0, 0, 4'hC, 32'hE, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(0, 0, 0, 0, 4'hE, 32'hE, 0));
    tbl.push_back(v(0, 0, 3, 0, 4'hE, 32'h1, 0));
    // mask, W1C of zero, W1C of one
    tbl.push_back(v(0, 1, 2, 32'h1, 4'hE, 32'h0, 1));
    tbl.push_back(v(0, 0, 2, 0,     4'hE, 32'h1, 1));
    tbl.push_back(v(0, 1, 3, 32'h0, 4'hE, 32'h1, 1));
    tbl.push_back(v(0, 0, 3, 0,     4'hE, 32'h1, 1));
    tbl.push_back(v(0, 1, 3, 32'h1, 4'hE, 32'h1, 0));
    tbl.push_back(v(0, 0, 3, 0,     4'hE, 32'h0, 0));

    @(negedge clk);
    foreach (tbl[k]) begin
      cyc(tbl[k].rst, tbl[k].wr, tbl[k].addr, tbl[k].wd, tbl[k].inp);
      check32($sformatf("vec%0d_readdata", k), bus_if.readdata, tbl[k].exp_rd);
      check32($sformatf("vec%0d_irq", k), {31'd0, irq}, {31'd0, tbl[k].exp_irq});
    end

    // edge on key 2 lands on the same clock as a W1C of that bit
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 4'hA);
    cyc(0, 0, 3, 0, 4'hA);
    check32("k2_first_capture", bus_if.readdata, 32'h4);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 4'hE);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 4'hA);
    cyc(0, 1, 3, 32'h4, 4'hA);
    cyc(0, 0, 3, 0, 4'hA);
    check32("set_beats_w1c", bus_if.readdata, 32'h4);
    cyc(0, 1, 3, 32'hF, 4'hA);
    cyc(0, 0, 3, 0, 4'hA);
    check32("w1c_all", bus_if.readdata, 32'h0);

    // reset in the middle of a key 3 debounce
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 4'hF);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 4'h7);
    cyc(1, 0, 0, 0, 4'h7);
    check32("midreset_readdata", bus_if.readdata, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 0, 0, 0, 4'h7);
      check32($sformatf("post_reset_data_%0d", i), bus_if.readdata, 32'hF);
    end
    cyc(0, 0, 0, 0, 4'h7);
    check32("post_reset_data_7", bus_if.readdata, 32'h7);
    cyc(0, 0, 3, 0, 4'h7);
    check32("post_reset_edgecap", bus_if.readdata, 32'h8);

    // randomized traffic
    begin
      logic [3:0] ip;
      int hold;
      ip = 4'h7; hold = 0;
      for (int n = 0; n < 3000; n++) begin
        logic r, w;
        logic [1:0] a;
        if (hold == 0) begin
          ip   = 4'($urandom_range(0, 15));
          hold = $urandom_range(1, 8);
        end
        hold--;
        r = ($urandom_range(0, 299) == 0);
        w = ($urandom_range(0, 3) == 0);
        a = 2'($urandom_range(0, 3));
        cyc(r, w, a, $urandom(), ip);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
